// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: scoreboard entry and forward select.
// Register fields are stored at a fixed maximum width so the struct need not be parametrised.
package hazard_pkg;
    localparam int RW_MAX   = 8;
    localparam int FSEL_MAX = 3;

    typedef logic [RW_MAX-1:0]   reg_addr_t;
    typedef logic [FSEL_MAX-1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF = '0;

    typedef struct packed {
        logic      valid;
        logic      wen;
        reg_addr_t wsel;
        logic      load;
        logic      memop;
        reg_addr_t rs;
        reg_addr_t rt;
        logic      halt;
    } sb_entry_t;
endpackage

// File: rtl/fwd_select.sv
// Youngest-match forward-source encoder over scoreboard entries 2..NREG-1.
// Purely combinational; returns k for a match in entry k+1, FWD_RF when nothing matches.
module fwd_select
    import hazard_pkg::*;
#(
    parameter int NREG  = 4,
    parameter int FSELW = $clog2(NREG)
) (
    input  sb_entry_t        ent_i [NREG-1:1],
    input  reg_addr_t        src_i,
    output logic [FSELW-1:0] sel_o
);
    fwd_sel_t sel_full;
    logic     unused_ok;

    always_comb begin
        sel_full  = FWD_RF;
        unused_ok = 1'b0;
        // Oldest first so the youngest match overwrites; a load still in entry 2 has no data yet.
        for (int k = NREG-2; k >= 1; k--) begin
            if (ent_i[k+1].valid && ent_i[k+1].wen && (ent_i[k+1].wsel != '0) &&
                (ent_i[k+1].wsel == src_i) && !((k == 1) && ent_i[k+1].load)) begin
                sel_full = fwd_sel_t'(k);
            end
        end
        for (int k = 1; k <= NREG-1; k++) begin
            unused_ok = unused_ok ^ (^ent_i[k]);
        end
        unused_ok = unused_ok ^ (^sel_full);
    end

    assign sel_o = FSELW'(sel_full);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline enable/flush/forward control from a scoreboard of in-flight instructions; outputs are
// combinational, halt latches one cycle after leaving the last reg. HAZARD_PERF_EN adds perf counters.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int NREG  = 4,
    parameter int RW    = 5,
    parameter int FSELW = $clog2(NREG)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic [RW-1:0]    id_rs,
    input  logic [RW-1:0]    id_rt,
    input  logic [RW-1:0]    id_wsel,
    input  logic             id_wen,
    input  logic             id_load,
    input  logic             id_memop,
    input  logic             id_halt,
    input  logic             ex_taken,
    output logic             pc_en,
    output logic [NREG-1:0]  stage_en,
    output logic [NREG-1:0]  stage_flush,
    output logic [FSELW-1:0] fwd_a,
    output logic [FSELW-1:0] fwd_b,
`ifdef HAZARD_PERF_EN
    output logic [31:0]      stall_cnt,
    output logic [31:0]      flush_cnt,
    output logic [31:0]      fwd_cnt,
`endif
    output logic             halt
);
    sb_entry_t sb_q [NREG-1:1];
    sb_entry_t sb_d [NREG-1:1];
    sb_entry_t id_ent;
    logic      halt_q, halt_d;
    logic      mem_busy, load_use, halting;

    assign id_ent = '{valid: 1'b1, wen: id_wen, wsel: reg_addr_t'(id_wsel), load: id_load,
                      memop: id_memop, rs: reg_addr_t'(id_rs), rt: reg_addr_t'(id_rt),
                      halt: id_halt};

    assign mem_busy = sb_q[2].valid && sb_q[2].memop && !dhit;
    assign load_use = sb_q[1].valid && sb_q[1].load && (sb_q[1].wsel != '0) &&
                      ((sb_q[1].wsel == id_ent.rs) || (sb_q[1].wsel == id_ent.rt));

    always_comb begin
        halting = 1'b0;
        for (int k = 1; k <= NREG-1; k++) begin
            halting = halting | (sb_q[k].valid & sb_q[k].halt);
        end
    end

    always_comb begin
        pc_en       = 1'b1;
        stage_en    = '1;
        stage_flush = '0;
        if (RST || halt_q) begin
            pc_en       = 1'b0;
            stage_en    = '0;
            stage_flush = '1;
        end else if (mem_busy) begin
            pc_en    = 1'b0;
            stage_en = '0;
        end else if (ex_taken) begin
            stage_flush[1:0] = 2'b11;
        end else if (load_use) begin
            pc_en          = 1'b0;
            stage_en[0]    = 1'b0;
            stage_flush[1] = 1'b1;
        end else if (halting || !ihit) begin
            pc_en          = 1'b0;
            stage_flush[0] = 1'b1;
        end
    end

    // Stages 1..NREG-1 always share one enable, so stage_en[1] is the scoreboard advance.
    always_comb begin
        sb_d   = sb_q;
        halt_d = halt_q;
        if (stage_en[1]) begin
            for (int k = NREG-1; k >= 2; k--) begin
                sb_d[k] = sb_q[k-1];
            end
            sb_d[1] = stage_flush[1] ? '0 : id_ent;
        end
        if (sb_q[NREG-1].valid && sb_q[NREG-1].halt && stage_en[NREG-1]) begin
            halt_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 1; k <= NREG-1; k++) begin
                sb_q[k] <= '0;
            end
            halt_q <= 1'b0;
        end else begin
            sb_q   <= sb_d;
            halt_q <= halt_d;
        end
    end

    assign halt = halt_q;

    fwd_select #(.NREG(NREG), .FSELW(FSELW)) u_fwd_a (
        .ent_i (sb_q),
        .src_i (sb_q[1].rs),
        .sel_o (fwd_a)
    );

    fwd_select #(.NREG(NREG), .FSELW(FSELW)) u_fwd_b (
        .ent_i (sb_q),
        .src_i (sb_q[1].rt),
        .sel_o (fwd_b)
    );

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q, fwd_cnt_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            if (!pc_en && !halt_q) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (ex_taken && stage_en[1]) flush_cnt_q <= flush_cnt_q + 32'd1;
            if (((fwd_a != '0) || (fwd_b != '0)) && stage_en[1]) fwd_cnt_q <= fwd_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign fwd_cnt   = fwd_cnt_q;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl at NREG=4, RW=5.
module tb_pipeline_hazard_ctrl;
    logic       CLK = 1'b0;
    logic       RST, ihit, dhit, ex_taken;
    logic [4:0] id_rs, id_rt, id_wsel;
    logic       id_wen, id_load, id_memop, id_halt;
    logic       pc_en, halt;
    logic [3:0] stage_en, stage_flush;
    logic [1:0] fwd_a, fwd_b;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt, flush_cnt, fwd_cnt;
`endif

    int npass  = 0;
    int ntotal = 0;

    pipeline_hazard_ctrl #(.NREG(4), .RW(5)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .ihit       (ihit),
        .dhit       (dhit),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_wsel    (id_wsel),
        .id_wen     (id_wen),
        .id_load    (id_load),
        .id_memop   (id_memop),
        .id_halt    (id_halt),
        .ex_taken   (ex_taken),
        .pc_en      (pc_en),
        .stage_en   (stage_en),
        .stage_flush(stage_flush),
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b),
`ifdef HAZARD_PERF_EN
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt),
        .fwd_cnt    (fwd_cnt),
`endif
        .halt       (halt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] ws,
                          input logic wen, input logic ld, input logic mo, input logic hl);
        id_rs    = rs;
        id_rt    = rt;
        id_wsel  = ws;
        id_wen   = wen;
        id_load  = ld;
        id_memop = mo;
        id_halt  = hl;
    endtask

    task automatic idle();
        set_id(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1; ihit = 1'b1; dhit = 1'b1; ex_taken = 1'b0;
        idle();
        #1;
        chk("rst_pc_en", pc_en, 0);
        chk("rst_stage_en", stage_en, 4'h0);
        chk("rst_flush", stage_flush, 4'hF);
        chk("rst_fwd_a", fwd_a, 0);
        chk("rst_fwd_b", fwd_b, 0);
        chk("rst_halt", halt, 0);
        RST = 1'b0;
        #1;
        chk("run_pc_en", pc_en, 1);
        chk("run_stage_en", stage_en, 4'hF);
        chk("run_flush", stage_flush, 4'h0);

        // lw r2 followed by add r3,r2,r4
        set_id(5'd1, 5'd2, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(5'd2, 5'd4, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("lu_pc_en", pc_en, 0);
        chk("lu_stage_en", stage_en, 4'b1110);
        chk("lu_flush", stage_flush, 4'b0010);
        tick();
        chk("lu_resume_pc_en", pc_en, 1);
        chk("lu_resume_stage_en", stage_en, 4'hF);
        tick();
        chk("lu_fwd_a", fwd_a, 2);
        chk("lu_fwd_b", fwd_b, 0);

        // add r1,r6,r7 then sub r5,r1,r1
        set_id(5'd6, 5'd7, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        set_id(5'd1, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("b2b_pc_en", pc_en, 1);
        chk("b2b_stage_en", stage_en, 4'hF);
        tick();
        chk("b2b_fwd_a", fwd_a, 1);
        chk("b2b_fwd_b", fwd_b, 1);
        // producer writing r0, consumer reading r0
        set_id(5'd8, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        set_id(5'd0, 5'd0, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("r0_fwd_a", fwd_a, 0);
        chk("r0_fwd_b", fwd_b, 0);

        // branch taken in the same cycle as a load-use hazard
        set_id(5'd1, 5'd0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(5'd9, 5'd0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
        ex_taken = 1'b1;
        #1;
        chk("br_lu_flush", stage_flush, 4'b0011);
        chk("br_lu_pc_en", pc_en, 1);
        chk("br_lu_stage_en", stage_en, 4'hF);
        tick();
        ex_taken = 1'b0;
        idle();
        #1;
        chk("br_after_pc_en", pc_en, 1);
        chk("br_after_flush", stage_flush, 4'h0);
        tick();
        // branch with icache miss, then miss alone
        ihit = 1'b0;
        ex_taken = 1'b1;
        #1;
        chk("br_miss_pc_en", pc_en, 1);
        chk("br_miss_flush", stage_flush, 4'b0011);
        tick();
        ex_taken = 1'b0;
        #1;
        chk("imiss_pc_en", pc_en, 0);
        chk("imiss_flush", stage_flush, 4'b0001);
        chk("imiss_stage_en", stage_en, 4'hF);
        ihit = 1'b1;
        tick();

        // store reaches reg 2, dcache misses for three cycles
        set_id(5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        idle();
        tick();
        dhit = 1'b0;
        #1;
        chk("dmiss1_stage_en", stage_en, 4'h0);
        chk("dmiss1_pc_en", pc_en, 0);
        tick();
        ex_taken = 1'b1;
        #1;
        chk("dmiss2_stage_en", stage_en, 4'h0);
        chk("dmiss2_pc_en", pc_en, 0);
        tick();
        chk("dmiss3_stage_en", stage_en, 4'h0);
        chk("dmiss3_pc_en", pc_en, 0);
        tick();
        dhit = 1'b1;
        #1;
        chk("dhit_stage_en", stage_en, 4'hF);
        chk("dhit_pc_en", pc_en, 1);
        chk("dhit_br_flush", stage_flush, 4'b0011);
        tick();
        ex_taken = 1'b0;

        // halt in decode; halt rises NREG cycles later and sticks
        set_id(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        chk("h0_pc_en", pc_en, 1);
        tick();
        idle();
        #1;
        chk("h1_pc_en", pc_en, 0);
        chk("h1_flush", stage_flush, 4'b0001);
        chk("h1_stage_en", stage_en, 4'hF);
        chk("h1_halt", halt, 0);
        tick();
        chk("h2_halt", halt, 0);
        tick();
        chk("h3_halt", halt, 0);
        chk("h3_stage_en", stage_en, 4'hF);
        tick();
        chk("h4_halt", halt, 1);
        chk("h4_stage_en", stage_en, 4'h0);
        chk("h4_pc_en", pc_en, 0);
        tick();
        tick();
        chk("h6_halt", halt, 1);
        #1;
        RST = 1'b1;
        #1;
        chk("rst_halt_cleared", halt, 0);
        chk("rst_halt_stage_en", stage_en, 4'h0);
        chk("rst_halt_flush", stage_flush, 4'hF);
`ifdef HAZARD_PERF_EN
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_flush_cnt", flush_cnt, 0);
        chk("rst_fwd_cnt", fwd_cnt, 0);
`endif
        RST = 1'b0;
        #1;
        chk("post_rst_pc_en", pc_en, 1);

        // reset asserted in the middle of a load-use stall
        set_id(5'd1, 5'd2, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(5'd2, 5'd4, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("stall2_stage_en", stage_en, 4'b1110);
        #1;
        RST = 1'b1;
        #1;
        chk("rst_stall_stage_en", stage_en, 4'h0);
        chk("rst_stall_flush", stage_flush, 4'hF);
        chk("rst_stall_pc_en", pc_en, 0);
        chk("rst_stall_fwd_a", fwd_a, 0);
        RST = 1'b0;
        idle();
        #1;
        chk("final_pc_en", pc_en, 1);
        chk("final_stage_en", stage_en, 4'hF);
        tick();
        tick();

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
